pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) from the main decoder's per-instruction flags.
//  Tracks dest/control of in-flight instructions in internal shadow registers. Generates EX forwarding selects,
//  load-use stalls, branch/jump flushes and a data-memory wait freeze with a timeout watchdog.
//  Sits beside the decoder in ID. Drives the enable/clear pins of the PC and IF/ID, ID/EX, EX/MEM, MEM/WB registers.
// PARAMETERS
//  RA_W        5    register-address width
//  MEM_TIMEOUT 255  max consecutive dmem_ready-low cycles before mem_timeout (>=1)
//  CNT_W       8    wait-counter width; MEM_TIMEOUT must fit in it
// PORTS
//  clk           in   1     single clock, all state on rising edge
//  rst_n         in   1     synchronous reset, active low
//  id_rs,id_rt   in   RA_W  source regs of instruction in ID
//  id_use_rs/rt  in   1     instruction in ID reads rs / rt
//  id_dest       in   RA_W  write reg after regDest mux
//  id_regWrite   in   1     decoder regWrite
//  id_memtoReg   in   1     decoder memtoReg (load)
//  id_memWrite   in   1     decoder memWrite (store)
//  id_jump       in   1     decoder jump
//  ex_br_taken   in   1     branch in EX resolved taken
//  dmem_ready    in   1     data memory completes access this cycle
//  stall_f       out  1     hold PC
//  stall_d       out  1     hold IF/ID
//  flush_d       out  1     clear IF/ID to NOP
//  flush_e       out  1     load bubble into ID/EX
//  freeze        out  1     hold ID/EX, EX/MEM, MEM/WB (and PC, IF/ID)
//  fwd_a, fwd_b  out  2     EX operand sel: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
//  mem_timeout   out  1     sticky watchdog error
// BEHAVIOUR
//  Shadows E/M/W: {valid, rs, rt, dest, regWrite, memtoReg, memAcc}.
//  Advance ID->E->M->W each cycle unless freeze. On stall or flush_e, E loads a bubble (all fields 0).
//  Reset (rst_n=0 at edge): all shadows 0, FSM=RUN, wait_cnt=0, mem_timeout=0. Outputs are combinational from
//   that state: all stalls/flushes/freeze 0, fwd 00.
//  Forwarding, per operand X in {rs,rt} of E: M.regWrite & M.dest!=0 & M.dest==E.X -> 10;
//   else W.regWrite & W.dest!=0 & W.dest==E.X -> 01; else 00. MEM beats WB. Reg 0 never forwarded.
//  Load-use: E.memtoReg & E.dest!=0 & ((id_use_rs & id_rs==E.dest)|(id_use_rt & id_rt==E.dest))
//   -> stall_f=stall_d=flush_e=1 for exactly one cycle.
//  Jump in ID: flush_d=1 same cycle (drops the fall-through fetch); 0-cycle decision, 1-cycle penalty.
//  Branch taken in EX: flush_d=flush_e=1 same cycle; overrides load-use stall (stall_f/stall_d=0).
//  FSM RUN: M.memAcc & !dmem_ready -> MEM_WAIT; freeze=1 combinationally this cycle; wait_cnt<=1.
//  FSM MEM_WAIT: freeze=1 while !dmem_ready; wait_cnt++ saturating. dmem_ready=1 -> RUN, freeze=0 that cycle, cnt<=0.
//   wait_cnt reaching MEM_TIMEOUT sets mem_timeout (sticky until reset). State remains MEM_WAIT.
//  Priority: freeze > branch flush > load-use stall > jump flush. While freeze=1: stall/flush outputs forced 0,
//   shadows held; pending hazards re-evaluate when freeze drops (pipeline inputs are held stable).
//  Simultaneous load-use and jump in ID: stall wins; jump flush follows on the next cycle.
//  Reset mid-MEM_WAIT or mid-stall: next cycle is RUN with empty shadows, no residual stall.
// TESTING
//  lw $2 then add $3,$2,$4 back-to-back -> one cycle stall_f=stall_d=flush_e=1; next cycle fwd_a=01.
//  add $5 (in M) and add $5 (in W), EX reads $5 -> fwd_a=10 (MEM priority); dest=$0 in M -> fwd_a=00.
//  ex_br_taken=1 with load-use pending in ID -> flush_d=flush_e=1, stall_f=0 that cycle.
//  sw in M, dmem_ready low 3 cycles -> freeze=1 for 3 cycles, 0 on 4th; mem_timeout stays 0.
//  MEM_TIMEOUT=4, dmem_ready held low 10 cycles -> mem_timeout=1 from 4th wait cycle, sticky after ready.
//  rst_n=0 for one edge during MEM_WAIT with load-use pending -> next cycle all outputs 0, mem_timeout=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
//   Keeps shadow copies of the instructions in EX, MEM and WB and uses them
//   to produce EX operand forwarding selects, load-use stalls, branch/jump
//   flushes and a data-memory wait freeze guarded by a sticky timeout flag.
//
// Ports
//   clk                  clock, all state on rising edge
//   rst_n                synchronous reset, active low
//   id_rs, id_rt         source registers of the instruction in ID
//   id_use_rs, id_use_rt ID instruction actually reads rs / rt
//   id_dest              destination register (after regDest mux)
//   id_regWrite          ID instruction writes the register file
//   id_memtoReg          ID instruction is a load
//   id_memWrite          ID instruction is a store
//   id_jump              ID instruction is a jump
//   ex_br_taken          branch in EX resolved taken
//   dmem_ready           data memory completes its access this cycle
//   stall_f, stall_d     hold PC / IF/ID
//   flush_d, flush_e     clear IF/ID / load a bubble into ID/EX
//   freeze               hold the whole pipeline while memory is busy
//   fwd_a, fwd_b         EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   mem_timeout          sticky: memory stayed busy for MEM_TIMEOUT cycles
//
// State      | meaning
// RUN        | pipeline advancing normally
// MEM_WAIT   | access in MEM not yet acknowledged, pipeline frozen

module pipeline_hazard_ctrl #(
   parameter int RA_W        = 5,
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            id_use_rs,
   input  logic            id_use_rt,
   input  logic [RA_W-1:0] id_dest,
   input  logic            id_regWrite,
   input  logic            id_memtoReg,
   input  logic            id_memWrite,
   input  logic            id_jump,
   input  logic            ex_br_taken,
   input  logic            dmem_ready,
   output logic            stall_f,
   output logic            stall_d,
   output logic            flush_d,
   output logic            flush_e,
   output logic            freeze,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic            mem_timeout
);

   typedef struct packed {
      logic            valid;
      logic [RA_W-1:0] rs;
      logic [RA_W-1:0] rt;
      logic [RA_W-1:0] dest;
      logic            reg_write;
      logic            mem_to_reg;
      logic            mem_acc;
   } shadow_t;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t             state, state_next;
   shadow_t            sh_e, sh_m, sh_w, id_entry;
   logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
   logic               timeout_q;
   logic               load_use;

   // MEM result wins over WB result; register 0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src,
                                          input shadow_t m,
                                          input shadow_t w);
      if (m.valid && m.reg_write && (m.dest != '0) && (m.dest == src))
         return 2'b10;
      else if (w.valid && w.reg_write && (w.dest != '0) && (w.dest == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      id_entry.valid      = 1'b1;
      id_entry.rs         = id_rs;
      id_entry.rt         = id_rt;
      id_entry.dest       = id_dest;
      id_entry.reg_write  = id_regWrite;
      id_entry.mem_to_reg = id_memtoReg;
      id_entry.mem_acc    = id_memtoReg | id_memWrite;
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = '0;
      freeze        = 1'b0;
      stall_f       = 1'b0;
      stall_d       = 1'b0;
      flush_d       = 1'b0;
      flush_e       = 1'b0;

      load_use = sh_e.valid && sh_e.mem_to_reg && (sh_e.dest != '0) &&
                 ((id_use_rs && (id_rs == sh_e.dest)) ||
                  (id_use_rt && (id_rt == sh_e.dest)));

      case (state)
         RUN: begin
            if (sh_m.valid && sh_m.mem_acc && !dmem_ready) begin
               freeze        = 1'b1;
               state_next    = MEM_WAIT;
               wait_cnt_next = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            if (!dmem_ready) begin
               freeze = 1'b1;
               if (wait_cnt != '1)
                  wait_cnt_next = wait_cnt + CNT_W'(1);
               else
                  wait_cnt_next = wait_cnt;
            end else begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase

      // While frozen the hazard outputs stay low; whatever is pending is
      // re-evaluated once the memory access completes.
      if (!freeze) begin
         if (ex_br_taken) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end else if (id_jump) begin
            flush_d = 1'b1;
         end
      end

      fwd_a = fwd_sel(sh_e.rs, sh_m, sh_w);
      fwd_b = fwd_sel(sh_e.rt, sh_m, sh_w);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
         sh_e      <= '0;
         sh_m      <= '0;
         sh_w      <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (wait_cnt_next == CNT_W'(MEM_TIMEOUT))
            timeout_q <= 1'b1;
         if (!freeze) begin
            sh_w <= sh_m;
            sh_m <= sh_e;
            sh_e <= flush_e ? '0 : id_entry;
         end
      end
   end

   assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int TMO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] id_rs, id_rt, id_dest;
   logic       id_use_rs, id_use_rt, id_regWrite, id_memtoReg, id_memWrite, id_jump;
   logic       ex_br_taken, dmem_ready;
   logic       stall_f, stall_d, flush_d, flush_e, freeze, mem_timeout;
   logic [1:0] fwd_a, fwd_b;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.RA_W(5), .MEM_TIMEOUT(TMO), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_dest(id_dest), .id_regWrite(id_regWrite), .id_memtoReg(id_memtoReg),
      .id_memWrite(id_memWrite), .id_jump(id_jump), .ex_br_taken(ex_br_taken),
      .dmem_ready(dmem_ready),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout)
   );

   // reference model: the three in-flight instructions and a busy-run length
   typedef struct packed {
      logic [4:0] rs, rt, dest;
      logic       rw, ld, ma;
   } ins_t;

   ins_t pe, pm, pw;
   int   low_run;
   bit   to_flag;
   bit   hold_id, hold_br;
   bit   e_sf, e_sd, e_fd, e_fe, e_fz;
   bit [1:0] e_fa, e_fb;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit [1:0] src_of(input logic [4:0] x);
      if (pm.rw && pm.dest != 0 && pm.dest == x) return 2'b10;
      if (pw.rw && pw.dest != 0 && pw.dest == x) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_clear();
      pe = '0; pm = '0; pw = '0;
      low_run = 0; to_flag = 0;
      hold_id = 0; hold_br = 0;
   endtask

   task automatic model_eval();
      bit lu;
      e_fz = pm.ma && !dmem_ready;
      lu = pe.ld && pe.dest != 0 &&
           ((id_use_rs && id_rs == pe.dest) || (id_use_rt && id_rt == pe.dest));
      {e_sf, e_sd, e_fd, e_fe} = 4'b0;
      if (!e_fz) begin
         if (ex_br_taken)  begin e_fd = 1; e_fe = 1; end
         else if (lu)      begin e_sf = 1; e_sd = 1; e_fe = 1; end
         else if (id_jump) e_fd = 1;
      end
      e_fa = src_of(pe.rs);
      e_fb = src_of(pe.rt);
   endtask

   // settle after the inputs changed at negedge, then compare every output
   task automatic check_all();
      #1;
      model_eval();
      chk("stall_f", stall_f, e_sf);
      chk("stall_d", stall_d, e_sd);
      chk("flush_d", flush_d, e_fd);
      chk("flush_e", flush_e, e_fe);
      chk("freeze", freeze, e_fz);
      chk("fwd_a", fwd_a, e_fa);
      chk("fwd_b", fwd_b, e_fb);
      chk("mem_timeout", mem_timeout, to_flag);
   endtask

   task automatic advance();
      ins_t nx;
      @(posedge clk);
      if (!rst_n) model_clear();
      else if (!e_fz) begin
         nx.rs = id_rs; nx.rt = id_rt; nx.dest = id_dest;
         nx.rw = id_regWrite; nx.ld = id_memtoReg; nx.ma = id_memtoReg | id_memWrite;
         pw = pm; pm = pe;
         pe = e_fe ? ins_t'('0) : nx;
         low_run = 0;
      end else begin
         low_run++;
         if (low_run == TMO) to_flag = 1;
      end
      hold_id = rst_n && (e_fz || e_sd);
      hold_br = rst_n && e_fz;
      @(negedge clk);
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                         input logic [4:0] dest, input bit rw, input bit ld, input bit mw, input bit jmp);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt; id_dest = dest;
      id_regWrite = rw; id_memtoReg = ld; id_memWrite = mw; id_jump = jmp;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         nop(); ex_br_taken = 0; dmem_ready = 1;
         check_all(); advance();
      end
   endtask

   task automatic do_reset();
      rst_n = 0;
      @(posedge clk);
      model_clear();
      @(negedge clk);
      rst_n = 1;
   endtask

   int burst;

   initial begin
      rst_n = 0; nop(); ex_br_taken = 0; dmem_ready = 1;
      model_clear();
      @(negedge clk);
      do_reset();

      // reset state
      check_all();
      chk("rst_stall_f", stall_f, 0);
      chk("rst_freeze", freeze, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_timeout", mem_timeout, 0);
      advance();

      // lw $2 ; add $3,$2,$4 -> one stall, then MEM/WB forwarding
      set_id(1, 2, 1, 0, 2, 1, 1, 0, 0); check_all(); advance();
      set_id(2, 4, 1, 1, 3, 1, 0, 0, 0); check_all();
      chk("lu_stall_f", stall_f, 1);
      chk("lu_stall_d", stall_d, 1);
      chk("lu_flush_e", flush_e, 1);
      advance();
      check_all();
      chk("lu_once", stall_f, 0);
      advance();
      nop(); check_all();
      chk("lu_fwd_a", fwd_a, 2'b01);
      chk("lu_fwd_b", fwd_b, 2'b00);
      advance();
      idle(3);

      // $5 written in M and W, EX reads $5 -> MEM wins; dest $0 never forwarded
      set_id(1, 1, 1, 1, 5, 1, 0, 0, 0); check_all(); advance();
      set_id(6, 7, 1, 1, 5, 1, 0, 0, 0); check_all(); advance();
      set_id(5, 0, 1, 1, 8, 1, 0, 0, 0); check_all(); advance();
      nop(); check_all();
      chk("prio_fwd_a", fwd_a, 2'b10);
      advance();
      set_id(1, 1, 1, 1, 0, 1, 0, 0, 0); check_all(); advance();
      set_id(0, 0, 1, 1, 9, 1, 0, 0, 0); check_all(); advance();
      nop(); check_all();
      chk("r0_fwd_a", fwd_a, 2'b00);
      advance();
      idle(3);

      // taken branch overrides a pending load-use stall
      set_id(1, 2, 1, 0, 2, 1, 1, 0, 0); check_all(); advance();
      set_id(2, 4, 1, 1, 3, 1, 0, 0, 0); ex_br_taken = 1; check_all();
      chk("br_flush_d", flush_d, 1);
      chk("br_flush_e", flush_e, 1);
      chk("br_stall_f", stall_f, 0);
      advance();
      ex_br_taken = 0;
      idle(3);

      // load-use together with jump: stall first, jump flush next cycle
      set_id(1, 2, 1, 0, 2, 1, 1, 0, 0); check_all(); advance();
      set_id(2, 0, 1, 0, 0, 0, 0, 0, 1); check_all();
      chk("lj_stall", stall_d, 1);
      chk("lj_no_flush_d", flush_d, 0);
      advance();
      check_all();
      chk("lj_flush_d", flush_d, 1);
      advance();
      idle(3);

      // store in M, memory busy 3 cycles
      set_id(1, 2, 1, 1, 0, 0, 0, 1, 0); check_all(); advance();
      nop(); check_all(); advance();
      for (int i = 0; i < 4; i++) begin
         dmem_ready = (i >= 3);
         check_all();
         chk("sw_freeze", freeze, (i < 3) ? 1 : 0);
         chk("sw_timeout", mem_timeout, 0);
         advance();
      end
      idle(3);

      // load in M, memory busy 10 cycles -> sticky timeout
      set_id(1, 0, 1, 0, 7, 1, 1, 0, 0); check_all(); advance();
      nop(); check_all(); advance();
      for (int i = 0; i < 10; i++) begin
         dmem_ready = 0;
         check_all();
         chk("to_freeze", freeze, 1);
         chk("to_flag", mem_timeout, (i >= 4) ? 1 : 0);
         advance();
      end
      dmem_ready = 1; check_all();
      chk("to_release", freeze, 0);
      chk("to_sticky", mem_timeout, 1);
      advance();
      idle(2);
      chk("to_sticky2", mem_timeout, 1);

      // reset during MEM_WAIT with a load-use pending
      set_id(1, 2, 1, 1, 0, 0, 0, 1, 0); check_all(); advance();
      set_id(1, 0, 1, 0, 2, 1, 1, 0, 0); check_all(); advance();
      set_id(2, 4, 1, 1, 3, 1, 0, 0, 0); dmem_ready = 0; check_all();
      chk("rw_freeze", freeze, 1);
      chk("rw_stall_masked", stall_f, 0);
      advance();
      rst_n = 0; check_all(); advance();
      rst_n = 1; check_all();
      chk("rw_freeze0", freeze, 0);
      chk("rw_stall0", stall_f, 0);
      chk("rw_flush_e0", flush_e, 0);
      chk("rw_timeout0", mem_timeout, 0);
      advance();
      idle(2);

      // randomized traffic against the model
      burst = 0;
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         if (!hold_id) begin
            int k;
            k = $urandom_range(0, 19);
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_use_rs = $urandom_range(0, 4) != 0;
            id_use_rt = $urandom_range(0, 1) != 0;
            id_dest = 5'($urandom_range(0, 3));
            id_regWrite = (k < 15);
            id_memtoReg = (k < 5);
            id_memWrite = (k >= 15 && k < 18);
            id_jump = (k >= 18);
         end
         if (!hold_br) ex_br_taken = ($urandom_range(0, 9) == 0);
         if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(1, 7);
         if (burst > 0) begin
            dmem_ready = 0;
            burst--;
         end else begin
            dmem_ready = ($urandom_range(0, 3) != 0);
         end
         check_all();
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
